nn_instr_decode: RTL

- Downstream neighbour of the instruction fetch stage in the NN simulator.
- Accepts 32-bit instruction words from fetch through a valid/ready handshake and buffers them in a small FIFO.
- Decodes each word into opcode and operand fields, and expands LOAD_W bursts into per-weight records.
- Presents decoded records through a registered valid/ready interface to the execute stage.

---
 rtl/nn_instr_decode.sv | 109 ++++++++++
 1 files changed

// File: rtl/nn_instr_decode.sv
// nn_instr_decode: buffers fetched instruction words in a FIFO, decodes them
// and expands LOAD_W bursts into per-weight records for the execute stage.
module nn_instr_decode #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr_data,
  output logic             instr_ready,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [2:0]       dec_op,
  output logic [3:0]       dec_layer,
  output logic [IDX_W-1:0] dec_neuron,
  output logic [11:0]      dec_imm,
  output logic [31:0]      dec_weight,
  output logic             err_illegal,
  output logic [7:0]       err_count,
  output logic             halted
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_DECODE, S_WEIGHTS, S_HALTED} state_t;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  state_t           r_state, w_state_nx;
  logic [IDX_W-1:0] r_base;
  logic [3:0]       r_layer;
  logic [11:0]      r_rem;
  logic [31:0]      w_word;
  logic [3:0]       w_opc;
  logic             w_push, w_load, w_in_w, w_illegal, w_emit, w_start_burst;
  logic [2:0]       w_op;
  logic [3:0]       w_layer;
  logic [IDX_W-1:0] w_neuron;
  logic [11:0]      w_imm;
  logic [31:0]      w_weight;
  assign w_word      = r_mem[r_rp];
  assign w_opc       = w_word[31:28];
  assign instr_ready = r_cnt != (AW+1)'(FIFO_DEPTH);
  assign w_push      = instr_valid && instr_ready;
  assign w_load      = (!dec_valid || dec_ready) && r_cnt != '0 && r_state != S_HALTED;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= instr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_DECODE;
    else        r_state <= w_state_nx;
  always_comb begin
    w_state_nx = r_state;
    if (w_load && w_in_w && r_rem == 12'd1) w_state_nx = S_DECODE;
    else if (w_start_burst)                 w_state_nx = S_WEIGHTS;
    else if (w_emit && !w_in_w && w_opc == 4'd4) w_state_nx = S_HALTED;
  end
  // Payload words bypass the opcode check entirely while a burst is open.
  always_comb begin
    w_in_w        = r_state == S_WEIGHTS;
    w_illegal     = w_load && !w_in_w && w_opc > 4'd4;
    w_emit        = w_load && !w_illegal;
    w_start_burst = w_emit && !w_in_w && w_opc == 4'd2 && w_word[11:0] != 12'd0;
    w_op          = w_in_w ? 3'd5 : w_opc[2:0];
    w_layer       = w_in_w ? r_layer : w_word[27:24];
    w_neuron      = w_in_w ? r_base : w_word[23:12];
    w_imm         = w_in_w ? r_rem - 12'd1 : w_word[11:0];
    w_weight      = w_in_w ? w_word : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_base      <= '0;
      r_layer     <= '0;
      r_rem       <= '0;
      dec_valid   <= 1'b0;
      dec_op      <= '0;
      dec_layer   <= '0;
      dec_neuron  <= '0;
      dec_imm     <= '0;
      dec_weight  <= '0;
      err_illegal <= 1'b0;
      err_count   <= '0;
      halted      <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_load) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_load);
      if (w_start_burst) begin
        r_base  <= w_word[23:12];
        r_layer <= w_word[27:24];
        r_rem   <= w_word[11:0];
      end else if (w_load && w_in_w) begin
        r_base <= r_base + IDX_W'(1);
        r_rem  <= r_rem - 12'd1;
      end
      if (w_emit) begin
        dec_valid  <= 1'b1;
        dec_op     <= w_op;
        dec_layer  <= w_layer;
        dec_neuron <= w_neuron;
        dec_imm    <= w_imm;
        dec_weight <= w_weight;
      end else if (dec_ready) dec_valid <= 1'b0;
      err_illegal <= w_illegal;
      if (w_illegal && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (dec_valid && dec_ready && dec_op == 3'd4) halted <= 1'b1;
    end
endmodule
